// File: rtl/perf_counter_unit.sv
// perf_counter_unit: performance monitor downstream of the pipeline writeback stage.
// Counts cycles, retired instructions, stalls and flushes while armed and not frozen.
// It also keeps an atomic snapshot of the cycle and retired-instruction counts.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   run_i          arms counting (pipeline out of reset and fetching)
//   freeze_i       holds all counters
//   clear_i        synchronous zeroing of counters and overflow flag
//   retire_i       a valid instruction completes W this cycle
//   stall_i        StallF asserted this cycle
//   flush_i        FlushE asserted this cycle
//   snap_i         capture cycle_count / instr_retired into the snapshot pair
//   cycle_count    cycles counted
//   instr_retired  retire pulses counted
//   stall_count    stall cycles counted (always 0 when STALL_FWD = 0)
//   flush_count    flush cycles counted
//   snap_cycles    snapshot of cycle_count
//   snap_instrs    snapshot of instr_retired
//   ovf_o          sticky: an increment was attempted on a saturated counter
//   state_o        00 IDLE, 01 COUNT, 10 FROZEN
module perf_counter_unit #(
  parameter int unsigned CNT_W     = 32,
  parameter bit          STALL_FWD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             freeze_i,
  input  logic             clear_i,
  input  logic             retire_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_retired,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] snap_cycles,
  output logic [CNT_W-1:0] snap_instrs,
  output logic             ovf_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StCount  = 2'b01,
    StFrozen = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] snap_cyc_q, snap_cyc_d;
  logic [CNT_W-1:0] snap_ins_q, snap_ins_d;
  logic             ovf_q, ovf_d;
  logic             count_en;
  logic             stall_inc;

  // Dropping run_i returns to IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (!run_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StCount;
        StCount:  if (freeze_i) state_d = StFrozen;
        StFrozen: if (!freeze_i) state_d = StCount;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Edges that leave COUNT, and the edge entering it, do not count.
  assign count_en  = (state_q == StCount) && (state_d == StCount);
  assign stall_inc = STALL_FWD && stall_i;

  always_comb begin
    cycle_d    = cycle_q;
    instr_d    = instr_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    ovf_d      = ovf_q;
    // Snapshot uses register values, so clear_i in the same cycle does not affect it.
    snap_cyc_d = snap_i ? cycle_q : snap_cyc_q;
    snap_ins_d = snap_i ? instr_q : snap_ins_q;
    if (clear_i) begin
      cycle_d = '0;
      instr_d = '0;
      stall_d = '0;
      flush_d = '0;
      ovf_d   = 1'b0;
    end else if (count_en) begin
      if (&cycle_q) ovf_d = 1'b1;
      else          cycle_d = cycle_q + One;
      if (retire_i) begin
        if (&instr_q) ovf_d = 1'b1;
        else          instr_d = instr_q + One;
      end
      if (stall_inc) begin
        if (&stall_q) ovf_d = 1'b1;
        else          stall_d = stall_q + One;
      end
      if (flush_i) begin
        if (&flush_q) ovf_d = 1'b1;
        else          flush_d = flush_q + One;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cycle_q    <= '0;
      instr_q    <= '0;
      stall_q    <= '0;
      flush_q    <= '0;
      snap_cyc_q <= '0;
      snap_ins_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      instr_q    <= instr_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      snap_cyc_q <= snap_cyc_d;
      snap_ins_q <= snap_ins_d;
      ovf_q      <= ovf_d;
    end
  end

  assign cycle_count   = cycle_q;
  assign instr_retired = instr_q;
  assign stall_count   = stall_q;
  assign flush_count   = flush_q;
  assign snap_cycles   = snap_cyc_q;
  assign snap_instrs   = snap_ins_q;
  assign ovf_o         = ovf_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Self-checking bench for perf_counter_unit: a 32-bit instance, a 4-bit instance for
// saturation, and a STALL_FWD=0 instance, all sharing one stimulus stream.
module tb_perf_counter_unit;

  logic clk = 1'b0;
  logic reset, run, freeze, clear, retire, stall, flush, snap;

  logic [31:0] c32, i32, s32, f32, sc32, si32;
  logic        ovf32;
  logic [1:0]  st32;
  logic [3:0]  c4, i4, s4, f4, sc4, si4;
  logic        ovf4;
  logic [1:0]  st4;
  logic [31:0] cns, ins, sns, fns, scns, sins;
  logic        ovfns;
  logic [1:0]  stns;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  perf_counter_unit #(.CNT_W(32), .STALL_FWD(1'b1)) dut (
    .clk(clk), .reset(reset), .run_i(run), .freeze_i(freeze), .clear_i(clear),
    .retire_i(retire), .stall_i(stall), .flush_i(flush), .snap_i(snap),
    .cycle_count(c32), .instr_retired(i32), .stall_count(s32), .flush_count(f32),
    .snap_cycles(sc32), .snap_instrs(si32), .ovf_o(ovf32), .state_o(st32)
  );

  perf_counter_unit #(.CNT_W(4), .STALL_FWD(1'b1)) dut4 (
    .clk(clk), .reset(reset), .run_i(run), .freeze_i(freeze), .clear_i(clear),
    .retire_i(retire), .stall_i(stall), .flush_i(flush), .snap_i(snap),
    .cycle_count(c4), .instr_retired(i4), .stall_count(s4), .flush_count(f4),
    .snap_cycles(sc4), .snap_instrs(si4), .ovf_o(ovf4), .state_o(st4)
  );

  perf_counter_unit #(.CNT_W(32), .STALL_FWD(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .run_i(run), .freeze_i(freeze), .clear_i(clear),
    .retire_i(retire), .stall_i(stall), .flush_i(flush), .snap_i(snap),
    .cycle_count(cns), .instr_retired(ins), .stall_count(sns), .flush_count(fns),
    .snap_cycles(scns), .snap_instrs(sins), .ovf_o(ovfns), .state_o(stns)
  );

  // Reference model: index 0 is the 32-bit width, index 1 the 4-bit width.
  longint unsigned m_cyc[2], m_ins[2], m_stl[2], m_fls[2], m_sc[2], m_si[2];
  bit              m_ovf[2];
  int              m_state;  // 0 idle, 1 count, 2 frozen
  longint unsigned maxv[2] = '{64'hFFFF_FFFF, 64'hF};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned sat_add(int w, longint unsigned v, bit inc);
    if (!inc) return v;
    if (v == maxv[w]) begin
      m_ovf[w] = 1'b1;
      return v;
    end
    return v + 1;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_cyc[w] = 0; m_ins[w] = 0; m_stl[w] = 0; m_fls[w] = 0;
      m_sc[w] = 0; m_si[w] = 0; m_ovf[w] = 1'b0;
    end
    m_state = 0;
  endtask

  task automatic model_step();
    bit counted;
    counted = (m_state == 1) && run && !freeze;
    for (int w = 0; w < 2; w++) begin
      if (snap) begin
        m_sc[w] = m_cyc[w];
        m_si[w] = m_ins[w];
      end
      if (clear) begin
        m_cyc[w] = 0; m_ins[w] = 0; m_stl[w] = 0; m_fls[w] = 0; m_ovf[w] = 1'b0;
      end else if (counted) begin
        m_cyc[w] = sat_add(w, m_cyc[w], 1'b1);
        m_ins[w] = sat_add(w, m_ins[w], retire);
        m_stl[w] = sat_add(w, m_stl[w], stall);
        m_fls[w] = sat_add(w, m_fls[w], flush);
      end
    end
    if (!run)              m_state = 0;
    else if (m_state == 0) m_state = 1;
    else                   m_state = freeze ? 2 : 1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".cyc32"},  64'(c32),   m_cyc[0]);
    check({tag, ".ins32"},  64'(i32),   m_ins[0]);
    check({tag, ".stl32"},  64'(s32),   m_stl[0]);
    check({tag, ".fls32"},  64'(f32),   m_fls[0]);
    check({tag, ".sc32"},   64'(sc32),  m_sc[0]);
    check({tag, ".si32"},   64'(si32),  m_si[0]);
    check({tag, ".ovf32"},  64'(ovf32), 64'(m_ovf[0]));
    check({tag, ".st32"},   64'(st32),  64'(m_state));
    check({tag, ".cyc4"},   64'(c4),    m_cyc[1]);
    check({tag, ".ins4"},   64'(i4),    m_ins[1]);
    check({tag, ".stl4"},   64'(s4),    m_stl[1]);
    check({tag, ".fls4"},   64'(f4),    m_fls[1]);
    check({tag, ".sc4"},    64'(sc4),   m_sc[1]);
    check({tag, ".si4"},    64'(si4),   m_si[1]);
    check({tag, ".ovf4"},   64'(ovf4),  64'(m_ovf[1]));
    check({tag, ".st4"},    64'(st4),   64'(m_state));
    check({tag, ".stlns"},  64'(sns),   64'd0);
    check({tag, ".cycns"},  64'(cns),   m_cyc[0]);
    check({tag, ".flsns"},  64'(fns),   m_fls[0]);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    freeze = 0; clear = 0; retire = 0; stall = 0; flush = 0; snap = 0;
  endtask

  initial begin
    logic [11:0] pat;
    reset = 1'b1;
    run = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    reset = 1'b0;

    // Arm: entry edge does not count, then 10 counted edges.
    run = 1'b1;
    tick("arm");
    check("arm_cyc", 64'(c32), 64'd0);
    repeat (10) tick("idle10");
    check("tp1_cyc", 64'(c32), 64'd10);
    check("tp1_ins", 64'(i32), 64'd0);
    check("tp1_state", 64'(st32), 64'd1);

    // Retire 7 of 12 cycles, then snapshot.
    clear = 1; tick("clr"); clear = 0;
    check("clr_cyc", 64'(c32), 64'd0);
    pat = 12'b1011_0101_1001;
    for (int i = 0; i < 12; i++) begin
      retire = pat[i];
      tick("ret");
    end
    retire = 0;
    check("tp2_ins", 64'(i32), 64'd7);
    check("tp2_cyc", 64'(c32), 64'd12);
    snap = 1; tick("snap"); snap = 0;
    check("tp2_snc", 64'(sc32), 64'd12);
    check("tp2_sni", 64'(si32), 64'd7);

    // Three stall cycles, flush overlapping the middle one.
    clear = 1; tick("clr"); clear = 0;
    for (int i = 0; i < 3; i++) begin
      stall = 1;
      flush = (i == 1);
      tick("stl");
    end
    stall = 0; flush = 0;
    check("tp3_stl", 64'(s32), 64'd3);
    check("tp3_fls", 64'(f32), 64'd1);
    check("tp3_cyc", 64'(c32), 64'd3);
    check("tp3_stlns", 64'(sns), 64'd0);

    // Freeze after 20 counted cycles with retire held high.
    clear = 1; tick("clr"); clear = 0;
    retire = 1;
    repeat (20) tick("pre_frz");
    freeze = 1;
    for (int i = 0; i < 5; i++) begin
      tick("frz");
      check("frz_cyc", 64'(c32), 64'd20);
      check("frz_ins", 64'(i32), 64'd20);
    end
    check("frz_state", 64'(st32), 64'd2);
    freeze = 0;
    tick("unfrz");
    check("unfrz_cyc", 64'(c32), 64'd20);
    repeat (3) tick("resume");
    check("resume_cyc", 64'(c32), 64'd23);
    check("resume_ins", 64'(i32), 64'd23);
    retire = 0;

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      run    = ($urandom_range(0, 19) != 0);
      freeze = ($urandom_range(0, 9) == 0);
      clear  = ($urandom_range(0, 39) == 0);
      retire = $urandom_range(0, 1);
      stall  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 5) == 0);
      snap   = ($urandom_range(0, 7) == 0);
      tick("rnd");
    end

    // 4-bit saturation: two clearing edges guarantee COUNT with zeroed counters.
    run = 1; idle_inputs();
    clear = 1;
    repeat (2) tick("pre_sat");
    clear = 0;
    repeat (18) tick("sat");
    check("sat_cyc4", 64'(c4), 64'd15);
    check("sat_ovf4", 64'(ovf4), 64'd1);
    check("sat_cyc32", 64'(c32), 64'd18);
    clear = 1; snap = 1;
    tick("clrsnap");
    clear = 0; snap = 0;
    check("cs_cyc4", 64'(c4), 64'd0);
    check("cs_ovf4", 64'(ovf4), 64'd0);
    check("cs_snc4", 64'(sc4), 64'd15);

    // Asynchronous reset mid-cycle during COUNT.
    retire = 1; stall = 1; flush = 1;
    repeat (5) tick("pre_rst");
    @(posedge clk);
    model_step();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_state", 64'(st32), 64'd0);
    check("arst_cyc", 64'(c32), 64'd0);
    check("arst_snc", 64'(sc32), 64'd0);
    compare_all("arst");
    #2;
    reset = 1'b0;
    idle_inputs();
    tick("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
